// File: rtl/cond_flag_unit.sv
// Condition-code evaluator and NZCV flag register for the ALU flag path.
// Optional debug overflow counter is built when COND_OVCNT_EN is defined.
module cond_flag_unit #(
  parameter int OV_CNT_W = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                InstrValid,
  input  logic [3:0]          Cond,
  input  logic [3:0]          ALUFlags,
  input  logic [1:0]          FlagW,
  input  logic                PCS,
  input  logic                RegW,
  input  logic                MemW,
  input  logic                NoWrite,
`ifdef COND_OVCNT_EN
  input  logic                OvClear,
  output logic [OV_CNT_W-1:0] OvCount,
`endif
  output logic                CondEx,
  output logic                PCSrc,
  output logic                RegWrite,
  output logic                MemWrite,
  output logic [3:0]          Flags
);

  logic [3:0] r_flags;
  logic       w_n;
  logic       w_z;
  logic       w_c;
  logic       w_v;
  logic       w_condEx;
  logic       w_commit;

  assign w_n = r_flags[3];
  assign w_z = r_flags[2];
  assign w_c = r_flags[1];
  assign w_v = r_flags[0];

  // Conditions always test the registered flags so back-to-back setters chain cleanly.
  always_comb begin
    w_condEx = 1'b0;
    unique case (Cond)
      4'b0000: w_condEx = w_z;
      4'b0001: w_condEx = ~w_z;
      4'b0010: w_condEx = w_c;
      4'b0011: w_condEx = ~w_c;
      4'b0100: w_condEx = w_n;
      4'b0101: w_condEx = ~w_n;
      4'b0110: w_condEx = w_v;
      4'b0111: w_condEx = ~w_v;
      4'b1000: w_condEx = w_c & ~w_z;
      4'b1001: w_condEx = ~w_c | w_z;
      4'b1010: w_condEx = (w_n == w_v);
      4'b1011: w_condEx = (w_n != w_v);
      4'b1100: w_condEx = ~w_z & (w_n == w_v);
      4'b1101: w_condEx = w_z | (w_n != w_v);
      4'b1110: w_condEx = 1'b1;
      default: w_condEx = 1'b0;
    endcase
  end

  assign w_commit = InstrValid & w_condEx;

  assign CondEx   = w_condEx;
  assign PCSrc    = PCS & w_commit;
  assign RegWrite = RegW & w_commit & ~NoWrite;
  assign MemWrite = MemW & w_commit;
  assign Flags    = r_flags;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_flags <= 4'b0000;
    end else if (w_commit) begin
      if (FlagW[1]) r_flags[3:2] <= ALUFlags[3:2];
      if (FlagW[0]) r_flags[1:0] <= ALUFlags[1:0];
    end
  end

`ifdef COND_OVCNT_EN
  logic [OV_CNT_W-1:0] r_ovCount;
  logic                w_ovInc;

  assign w_ovInc = w_commit & FlagW[0] & ALUFlags[0];
  assign OvCount = r_ovCount;

  // Clear takes priority over a same-cycle overflow; the count sticks at all-ones.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ovCount <= '0;
    end else if (OvClear) begin
      r_ovCount <= '0;
    end else if (w_ovInc && (r_ovCount != {OV_CNT_W{1'b1}})) begin
      r_ovCount <= r_ovCount + 1'b1;
    end
  end
`endif

endmodule
